// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_sequencer
// Brief    : Queues ALU commands, issues them with operands from a local
//            register file, writes results back and reports them. Optional
//            macro ALU_ILLEGAL_OP_CHECK_EN rejects opcodes above 5'b10001.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5,
    parameter int NREG   = 8,
    parameter int DEPTH  = 4,
    localparam int RW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [RW-1:0]     cmd_rd,
    input  logic [RW-1:0]     cmd_rs1,
    input  logic [RW-1:0]     cmd_rs2,
    input  logic              ld_en,
    input  logic [RW-1:0]     ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [RW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              alu_enable,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] src1,
    output logic [DATA_W-1:0] src2,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_overflow,
    output logic              rsp_valid,
    output logic [RW-1:0]     rsp_rd,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_ovf,
    output logic              ovf_sticky,
    input  logic              ovf_clr,
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    output logic              illegal_op,
`endif
    output logic              busy
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] c_full = (PW+1)'(DEPTH);
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    localparam logic [OP_W-1:0] c_max_op = OP_W'(17);
`endif

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Command FIFO storage and pointers
    logic [OP_W-1:0] r_fifo_op  [DEPTH];
    logic [RW-1:0]   r_fifo_rd  [DEPTH];
    logic [RW-1:0]   r_fifo_rs1 [DEPTH];
    logic [RW-1:0]   r_fifo_rs2 [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;

    logic [DATA_W-1:0] r_regs [NREG];

    logic              r_alu_enable;
    logic [OP_W-1:0]   r_alu_op;
    logic [DATA_W-1:0] r_src1;
    logic [DATA_W-1:0] r_src2;
    logic [RW-1:0]     r_exec_rd;
    logic              r_rsp_valid;
    logic [RW-1:0]     r_rsp_rd;
    logic [DATA_W-1:0] r_rsp_data;
    logic              r_rsp_ovf;
    logic              r_ovf_sticky;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    logic              r_illegal_op;
    logic              w_reject;
`endif

    logic            w_push;
    logic            w_pop;
    logic            w_issue;
    logic            w_writeback;
    logic            w_fifo_empty;
    logic [OP_W-1:0] w_head_op;
    logic [RW-1:0]   w_head_rd;
    logic [RW-1:0]   w_head_rs1;
    logic [RW-1:0]   w_head_rs2;

    assign w_fifo_empty = (r_count == '0);
    assign cmd_ready    = (r_count != c_full);
    assign w_push       = cmd_valid && cmd_ready;
    assign w_head_op    = r_fifo_op[r_rd_ptr];
    assign w_head_rd    = r_fifo_rd[r_rd_ptr];
    assign w_head_rs1   = r_fifo_rs1[r_rd_ptr];
    assign w_head_rs2   = r_fifo_rs2[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_issue      = 1'b0;
        w_writeback  = 1'b0;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
        w_reject     = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop = 1'b1;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
                    // Rejected commands never reach the ALU; FSM stays IDLE
                    if (w_head_op > c_max_op) begin
                        w_reject = 1'b1;
                    end else begin
                        w_issue      = 1'b1;
                        w_state_next = S_EXEC;
                    end
`else
                    w_issue      = 1'b1;
                    w_state_next = S_EXEC;
`endif
                end
            end
            S_EXEC: begin
                w_writeback  = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Payload storage needs no reset: only entries between the pointers are live
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_op[r_wr_ptr]  <= cmd_op;
            r_fifo_rd[r_wr_ptr]  <= cmd_rd;
            r_fifo_rs1[r_wr_ptr] <= cmd_rs1;
            r_fifo_rs2[r_wr_ptr] <= cmd_rs2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PW+1)'(1);
                2'b01:   r_count <= r_count - (PW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Writeback is assigned after the direct load so it wins on a clash
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (ld_en)       r_regs[ld_addr]   <= ld_data;
            if (w_writeback) r_regs[r_exec_rd] <= alu_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_enable <= 1'b0;
            r_alu_op     <= '0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_exec_rd    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rd     <= '0;
            r_rsp_data   <= '0;
            r_rsp_ovf    <= 1'b0;
            r_ovf_sticky <= 1'b0;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
            r_illegal_op <= 1'b0;
`endif
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_issue) begin
                r_alu_enable <= 1'b1;
                r_alu_op     <= w_head_op;
                r_src1       <= r_regs[w_head_rs1];
                r_src2       <= r_regs[w_head_rs2];
                r_exec_rd    <= w_head_rd;
            end
            if (w_writeback) begin
                r_alu_enable <= 1'b0;
                r_rsp_valid  <= 1'b1;
                r_rsp_rd     <= r_exec_rd;
                r_rsp_data   <= alu_out;
                r_rsp_ovf    <= alu_overflow;
            end
            if (w_writeback && alu_overflow) begin
                r_ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf_sticky <= 1'b0;
            end
`ifdef ALU_ILLEGAL_OP_CHECK_EN
            if (w_reject) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_rd     <= w_head_rd;
                r_rsp_data   <= '0;
                r_rsp_ovf    <= 1'b0;
                r_illegal_op <= 1'b1;
            end else if (ovf_clr) begin
                r_illegal_op <= 1'b0;
            end
`endif
        end
    end

    assign rd_data    = r_regs[rd_addr];
    assign alu_enable = r_alu_enable;
    assign alu_op     = r_alu_op;
    assign src1       = r_src1;
    assign src2       = r_src2;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rd     = r_rsp_rd;
    assign rsp_data   = r_rsp_data;
    assign rsp_ovf    = r_rsp_ovf;
    assign ovf_sticky = r_ovf_sticky;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
    assign illegal_op = r_illegal_op;
`endif
    assign busy       = !w_fifo_empty || (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Initiator-side driver for the combinational 32-bit ALU. Accepts ALU commands over a valid/ready handshake and buffers them in a small FIFO.
- Reads operands from a local register file and drives alu_enable/alu_op/src1/src2. Captures alu_out/alu_overflow, writes the result back and reports it on a response port.
- Sits between the control/testbench layer and the ALU datapath.

Parameters:
DATA_W, 32, operand/result width; must equal ALU data width
OP_W, 5, ALU opcode width
NREG, 8, register file entries (index width RW = log2(NREG) = 3)
DEPTH, 4, command FIFO depth (power of 2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO can accept a command
cmd_op  input  OP_W  ALU opcode
cmd_rd  input  RW  destination register
cmd_rs1  input  RW  source register 1
cmd_rs2  input  RW  source register 2
ld_en  input  1  direct register load strobe
ld_addr  input  RW  load register index
ld_data  input  DATA_W  load value
rd_addr  input  RW  debug read index
rd_data  output  DATA_W  combinational read of regfile[rd_addr]
alu_enable  output  1  to ALU
alu_op  output  OP_W  to ALU
src1  output  DATA_W  to ALU
src2  output  DATA_W  to ALU
alu_out  input  DATA_W  from ALU
alu_overflow  input  1  from ALU
rsp_valid  output  1  one-cycle result pulse
rsp_rd  output  RW  register written
rsp_data  output  DATA_W  result value
rsp_ovf  output  1  overflow of this result
ovf_sticky  output  1  sticky overflow flag
ovf_clr  input  1  clears ovf_sticky
busy  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async, rst_n=0):
  - FIFO emptied; FSM set to IDLE; all regfile entries set to 0.
  - alu_enable, alu_op, src1, src2, rsp_valid, rsp_rd, rsp_data, rsp_ovf and ovf_sticky all set to 0.
  - Reset mid-operation discards any in-flight command and any queued commands.
- FIFO:
  - cmd_ready = (count != DEPTH); it depends only on count, so there is no same-cycle pass-through when full.
  - Push on cmd_valid && cmd_ready. Pointers wrap modulo DEPTH.
  - Simultaneous push and pop when not full: count unchanged.
- FSM states: IDLE, EXEC.
  - IDLE, FIFO non-empty: pop head. On the same edge:
    - src1 <= reg[rs1], src2 <= reg[rs2], alu_op <= op, alu_enable <= 1.
    - Latch rd; go to EXEC.
  - IDLE, FIFO empty: alu_enable stays 0; alu_op, src1 and src2 hold their last values.
  - EXEC (ALU output valid this cycle): on the edge:
    - reg[rd] <= alu_out; rsp_data <= alu_out; rsp_ovf <= alu_overflow; rsp_rd <= rd; rsp_valid <= 1.
    - alu_enable <= 0; go to IDLE.
- Latency and throughput:
  - Command accepted in cycle T with empty FIFO and IDLE FSM: ALU driven in T+2, rsp_valid in T+3.
  - Throughput is one command per 2 cycles.
  - rsp_valid is high for exactly one cycle per command; there is no backpressure on rsp.
- Data hazard: writeback lands in the same edge as the return to IDLE. A dependent next command therefore reads the updated register with no stall.
- Register file write conflict: writeback and ld_en to the same register in the same edge → the writeback value wins. ld_en to a different register is performed in parallel.
- ovf_sticky: set on the EXEC edge when alu_overflow=1; cleared by ovf_clr; set wins if both occur in the same edge.
- Opcodes are passed to the ALU unmodified; the defined set is 5'b00000–5'b10001.

Optional Feature:
- Macro ALU_ILLEGAL_OP_CHECK_EN.
- Defined:
  - A popped command with op > 5'b10001 is not issued: alu_enable stays 0 and no regfile write occurs.
  - FSM stays IDLE. Next cycle: rsp_valid=1, rsp_rd=rd, rsp_data=0, rsp_ovf=0.
  - Output illegal_op (1-bit, sticky, reset 0, cleared by ovf_clr) is set.
- Undefined: no check; every opcode is issued. Port illegal_op is absent.

Test Plan:
- ld r1=5, r2=7; cmd ADD(00000) rd=3 rs1=1 rs2=2 at cycle T → alu_enable=1, src1=5, src2=7 in T+2; rsp_valid at T+3 with rsp_data=12, rsp_ovf=0; rd_addr=3 reads 12.
- ld r1=0x7FFFFFFF, r2=1; ADD rd=4 → rsp_data=0x80000000, rsp_ovf=1, ovf_sticky=1 and held; ovf_clr pulse → 0; ovf_clr together with a new overflow → stays 1.
- Dependency chain: SUB r5=r1-r2 (r1=10, r2=3) followed immediately by ADD r6=r5+r5 → responses 7 then 14, no stall beyond 2 cycles per command.
- Hold cmd_valid for 8 back-to-back commands → cmd_ready drops once 4 are queued; all 8 responses arrive in order with correct rsp_rd; busy falls after the last rsp_valid.
- Reset asserted during EXEC with 3 commands queued → all outputs 0 immediately; after release no rsp_valid occurs; all registers read 0.
- With ALU_ILLEGAL_OP_CHECK_EN: op=5'b11111 rd=2 → no alu_enable pulse, rsp_valid with rsp_data=0, illegal_op=1, r2 unchanged.
